// File: rtl/da_pkg.sv
// Shared constants and types for the distributed-arithmetic datapath.
package da_pkg;

    localparam int unsigned DA_W         = 4;
    localparam int unsigned DA_TAPS      = 3;
    localparam int unsigned DA_FRAME_LEN = 6;

    typedef logic signed [DA_W-1:0] da_sample_t;

endpackage

// File: rtl/da_sample_fifo.sv
// Small synchronous sample FIFO with registered full/empty flags and a level count.
// The caller never pushes while full and never pops while empty.
module da_sample_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    // Next-state: write at the write pointer, advance pointers (wrap by power-of-two overflow), track level.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/da_tap_feeder.sv
// Buffers a serial sample stream and presents a 3-tap delay line to the DA core,
// shifting only on the frame boundary so taps are stable for a whole DA frame.
// Optional build macro: DA_TAP_ZERO_STUFF_EN (shift in zero on an underrun boundary).
module da_tap_feeder
    import da_pkg::*;
#(
    parameter int unsigned W         = DA_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = DA_FRAME_LEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [W-1:0]                 s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [W-1:0]                 x0_out,
    output logic [W-1:0]                 x1_out,
    output logic [W-1:0]                 x2_out,
    output logic                         frame_start,
    output logic                         tap_valid,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  taps_q [DA_TAPS];
    logic [W-1:0]  taps_d [DA_TAPS];
    logic          tap_valid_q, tap_valid_d;
    logic          underrun_q, underrun_d;

    logic          push;
    logic          pop;
    logic          boundary;
    logic          shift;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  fifo_head;

    assign s_ready  = !fifo_full && !reset;
    assign push     = s_valid && s_ready;
    assign boundary = (count_q == CW'(FRAME_LEN - 1));
    // Pop uses the pre-edge empty flag, so a sample pushed on the boundary edge waits a frame.
    assign pop      = boundary && !fifo_empty;

    da_sample_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Free-running frame counter, 0..FRAME_LEN-1.
    always_comb begin
        count_d = count_q + CW'(1);
        if (boundary) begin
            count_d = '0;
        end
    end

    // Delay-line update on the boundary: shift in the FIFO head, or flag an underrun.
    always_comb begin
        taps_d      = taps_q;
        tap_valid_d = tap_valid_q;
        underrun_d  = underrun_q;
`ifdef DA_TAP_ZERO_STUFF_EN
        shift = boundary;
`else
        shift = pop;
`endif
        if (boundary) begin
            tap_valid_d = !fifo_empty;
            if (fifo_empty) begin
                underrun_d = 1'b1;
            end
        end
        if (shift) begin
            taps_d[0] = fifo_empty ? '0 : fifo_head;
            for (int i = 1; i < int'(DA_TAPS); i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            for (int i = 0; i < int'(DA_TAPS); i++) begin
                taps_q[i] <= '0;
            end
            tap_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            taps_q      <= taps_d;
            tap_valid_q <= tap_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign x0_out      = taps_q[0];
    assign x1_out      = taps_q[1];
    assign x2_out      = taps_q[2];
    assign tap_valid   = tap_valid_q;
    assign underrun    = underrun_q;
    // Load-cycle marker; suppressed while reset is held so the core never sees a spurious load.
    assign frame_start = (count_q == '0) && !reset;

endmodule

// File: tb/tb_da_tap_feeder.sv
// Scoreboard bench for da_tap_feeder: a queue-based model predicts the taps seen at
// every frame start; a monitor compares them plus per-cycle ready/level/frame_start.
module tb_da_tap_feeder;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] x0_out, x1_out, x2_out;
    logic         frame_start, tap_valid, underrun;
    logic [2:0]   fifo_level;

    always #5 clk = ~clk;

    da_tap_feeder #(.W(W), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .x0_out      (x0_out),
        .x1_out      (x1_out),
        .x2_out      (x2_out),
        .frame_start (frame_start),
        .tap_valid   (tap_valid),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    typedef struct {
        int x0;
        int x1;
        int x2;
        bit tv;
        bit un;
    } exp_t;

    exp_t exp_q[$];
    int   m_q[$];
    int   m_count;
    int   m_tap[3];
    bit   m_tv, m_un, m_accepted;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO as a queue, taps as an array, frame position as an integer.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_count    = 0;
            m_tap      = '{0, 0, 0};
            m_tv       = 0;
            m_un       = 0;
            m_accepted = 0;
            exp_q.delete();
            exp_q.push_back('{0, 0, 0, 1'b0, 1'b0});
        end else begin
            bit acc;
            int smp;
            acc = s_valid && (m_q.size() < DEPTH);
            smp = $signed(s_data);
            if (m_count == FL - 1) begin
                if (m_q.size() > 0) begin
                    m_tap[2] = m_tap[1];
                    m_tap[1] = m_tap[0];
                    m_tap[0] = m_q.pop_front();
                    m_tv = 1;
                end else begin
                    m_tv = 0;
                    m_un = 1;
`ifdef DA_TAP_ZERO_STUFF_EN
                    m_tap[2] = m_tap[1];
                    m_tap[1] = m_tap[0];
                    m_tap[0] = 0;
`endif
                end
                exp_q.push_back('{m_tap[0], m_tap[1], m_tap[2], m_tv, m_un});
            end
            if (acc) m_q.push_back(smp);
            m_accepted = acc;
            m_count = (m_count + 1) % FL;
        end
    end

    // Monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_x0", int'(x0_out), 0);
            check("rst_x1", int'(x1_out), 0);
            check("rst_x2", int'(x2_out), 0);
            check("rst_frame_start", int'(frame_start), 0);
            check("rst_tap_valid", int'(tap_valid), 0);
            check("rst_underrun", int'(underrun), 0);
            check("rst_level", int'(fifo_level), 0);
        end else begin
            check("s_ready", int'(s_ready), int'(m_q.size() < DEPTH));
            check("fifo_level", int'(fifo_level), m_q.size());
            check("frame_start", int'(frame_start), int'(m_count == 0));
            if (frame_start) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: frame_start with no expected entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("x0", int'($signed(x0_out)), e.x0);
                    check("x1", int'($signed(x1_out)), e.x1);
                    check("x2", int'($signed(x2_out)), e.x2);
                    check("tap_valid", int'(tap_valid), int'(e.tv));
                    check("underrun", int'(underrun), int'(e.un));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int c);
        int n;
        n = 0;
        while (m_count != c && n < 3 * FL) begin
            step();
            n++;
        end
        check("wait_count_timeout", int'(m_count == c), 1);
    endtask

    task automatic next_frame();
        step();
        wait_count(0);
    endtask

    // Hold a sample on the bus until the handshake completes.
    task automatic push1(input int v);
        int n;
        s_valid = 1'b1;
        s_data  = W'(v);
        step();
        n = 0;
        while (!m_accepted && n < 4 * FL) begin
            step();
            n++;
        end
        check("push_timeout", int'(m_accepted), 1);
        s_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then idle: taps zero, frame starts every FL cycles, underrun after first boundary.
        repeat (3) step();
        reset = 1'b0;
        repeat (14) step();

        // Three samples, one per frame.
        for (int v = 1; v <= 3; v++) begin
            wait_count(1);
            push1(v);
            wait_count(0);
        end
        // Empty boundary with taps 3/2/1.
        next_frame();

        // Burst of five right after a boundary; the fifth waits for a pop.
        wait_count(0);
        push1(-8);
        push1(7);
        push1(-1);
        push1(5);
        push1(4);
        repeat (6) next_frame();

        // Push exactly on the boundary edge into an empty FIFO.
        wait_count(FL - 1);
        s_valid = 1'b1;
        s_data  = W'(6);
        step();
        s_valid = 1'b0;
        repeat (2) next_frame();

        // Build taps 5/-3/7 with two buffered samples, then reset mid-frame.
        wait_count(1); push1(7);  wait_count(0);
        wait_count(1); push1(-3); wait_count(0);
        wait_count(1); push1(5);  wait_count(0);
        push1(1);
        push1(2);
        wait_count(3);
        check("pre_rst_level", int'(fifo_level), 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_x0", int'(x0_out), 0);
        check("async_rst_x1", int'(x1_out), 0);
        check("async_rst_x2", int'(x2_out), 0);
        check("async_rst_level", int'(fifo_level), 0);
        check("async_rst_frame_start", int'(frame_start), 0);
        step();
        step();
        reset = 1'b0;
        repeat (2 * FL) step();

        // Randomised traffic: sparse (underruns), dense (full FIFO), with one mid-run reset.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                int thr;
                thr = (ph == 0) ? 1 : (ph == 1) ? 9 : 3;
                s_valid = ($urandom_range(0, 9) < thr);
                s_data  = W'($urandom);
                if (ph == 2 && i == 100) begin
                    reset = 1'b1;
                    step();
                    step();
                    reset = 1'b0;
                end
                step();
            end
        end
        s_valid = 1'b0;
        repeat (3 * FL) step();
        check("sb_leftover", int'(exp_q.size() <= 1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
